pipe_hazard_unit: RTL and testbench
===================================

// Module: pipe_hazard_unit
// PURPOSE
//  Parametrised bypass/hazard unit for the pipelined core, replacing the per-operand bypass muxes and tag forwarders.
//  Tracks destination tags of in-flight instructions over STAGES post-ID stages and forwards the youngest result to each ID read port.
//  Detects load-use hazards and requests an ID stall plus an EX bubble; honours branch flush and a global freeze.
// PARAMETERS
//  DATA_W       16  operand/result width
//  REG_ADDR_W   4   register tag width (16 architectural regs incl. SP/IH/RA)
//  READ_PORTS   2   ID operand ports (S, M)
//  STAGES       2   tracked stages after ID; 0=EX, STAGES-1=writeback (ME)
//  LOAD_READY   1   first stage index at which load data is valid (1..STAGES-1)
// PORTS
//  clk          in   1                      clock
//  rst          in   1                      reset, synchronous, active-high
//  id_valid     in   1                      ID holds a real instruction
//  id_src_addr  in   READ_PORTS*REG_ADDR_W  source tags, port p at [p*REG_ADDR_W +: REG_ADDR_W]
//  id_src_used  in   READ_PORTS             port p reads a register
//  id_dst_addr  in   REG_ADDR_W             destination tag
//  id_dst_we    in   1                      instruction writes id_dst_addr
//  id_is_load   in   1                      instruction is a memory load
//  rf_rdata     in   READ_PORTS*DATA_W      register-file values per port
//  stage_result in   STAGES*DATA_W          result held in stage k (stage k-1 load data muxed in by datapath)
//  flush        in   1                      kill ID instruction (taken jump)
//  freeze       in   1                      global hold (memory busy)
//  fwd_data     out  READ_PORTS*DATA_W      bypassed operand per port
//  stall        out  1                      hold PC/IF/ID this cycle
//  stall_count  out  32                     load-use stall cycles (see CONFIGURATION)
// BEHAVIOUR
//  - State: per stage k, {vld, we, ld, dst}. Reset: all vld=0; stall=0; stall_count=0; fwd_data=rf_rdata (combinational).
//  - Match(p,k) = id_src_used[p] & vld[k] & we[k] & dst[k]==src[p].
//  - fwd_data[p] (0-cycle, combinational) = stage_result[k] for the smallest k with Match; else rf_rdata[p].
//    Youngest stage wins; stage STAGES-1 bypass covers the same-cycle register-file write.
//  - hazard = id_valid & exists p,k: Match(p,k) & ld[k] & k<LOAD_READY.
//  - stall = freeze | (hazard & ~flush). Flush wins over hazard.
//  - Advance (posedge, freeze=0): entry[k]<=entry[k-1], k>=1.
//    entry[0] <= {id_valid&~hazard&~flush, id_dst_we, id_is_load, id_dst_addr}; else bubble (vld=0).
//  - freeze=1: all entries hold; flush is ignored, so the driver holds flush until freeze drops.
//  - A stalled ID instruction re-evaluates each cycle; hazard clears once the load reaches LOAD_READY.
//    Default config gives exactly 1 bubble per load-use.
//  - Tags of invalid entries or we=0 entries never match; dst is compared at full REG_ADDR_W width.
//  - rst asserted mid-operation: all entries invalidated at that edge, counter cleared; rst wins over freeze.
// CONFIGURATION
//  HAZARD_STALL_CNT_EN defined: stall_count += 1 on each cycle hazard&~flush&~freeze&~rst.
//    Saturates at 32'hFFFF_FFFF, no wrap.
//  Not defined: no counter flops; stall_count tied to 32'h0.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> stall=0, stall_count=0, fwd_data==rf_rdata for any src.
//  2. ALU back-to-back: ADD R1 (dst=1), next src0=1, stage_result[0]=16'h1234, rf=16'h0000
//     -> fwd_data[0]=16'h1234, stall=0.
//  3. Priority: R2 in stage0 (16'hAAAA) and stage1 (16'hBBBB), src1=2 -> fwd_data[1]=16'hAAAA.
//  4. Load-use: LW R3 then src0=3 -> stall=1 one cycle, EX bubble inserted.
//     Next cycle fwd_data[0]=stage_result[1]=16'h00C3, stall_count=1 (macro on).
//  5. Flush vs hazard: same as 4 with flush=1 -> stall=0, entry[0].vld=0 next cycle, stall_count unchanged.
//  6. Freeze: freeze=1 for 3 cycles with tags in flight -> stall=1, tags unchanged.
//     rst during freeze -> all vld=0 next cycle.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// Operand bypass and load-use hazard unit tracking destination tags over STAGES post-ID stages.
// Optional load-use stall counter enabled by defining HAZARD_STALL_CNT_EN.
module pipe_hazard_unit #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int READ_PORTS = 2,
    parameter int STAGES     = 2,
    parameter int LOAD_READY = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             id_valid,
    input  logic [READ_PORTS*REG_ADDR_W-1:0] id_src_addr,
    input  logic [READ_PORTS-1:0]            id_src_used,
    input  logic [REG_ADDR_W-1:0]            id_dst_addr,
    input  logic                             id_dst_we,
    input  logic                             id_is_load,
    input  logic [READ_PORTS*DATA_W-1:0]     rf_rdata,
    input  logic [STAGES*DATA_W-1:0]         stage_result,
    input  logic                             flush,
    input  logic                             freeze,
    output logic [READ_PORTS*DATA_W-1:0]     fwd_data,
    output logic                             stall,
    output logic [31:0]                      stall_count
);

    logic                  vld_p [STAGES];
    logic                  we_p  [STAGES];
    logic                  ld_p  [STAGES];
    logic [REG_ADDR_W-1:0] dst_p [STAGES];

    logic match [READ_PORTS][STAGES];
    logic hazard;

    always_comb begin
        for (int p = 0; p < READ_PORTS; p++) begin
            for (int k = 0; k < STAGES; k++) begin
                match[p][k] = id_src_used[p] & vld_p[k] & we_p[k] &
                              (dst_p[k] == id_src_addr[p*REG_ADDR_W +: REG_ADDR_W]);
            end
        end
    end

    // ID stage: bypass select and hazard detect
    always_comb begin
        fwd_data = rf_rdata;
        hazard   = 1'b0;
        for (int p = 0; p < READ_PORTS; p++) begin
            // Walk oldest to youngest so the youngest matching stage is written last.
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (match[p][k]) begin
                    fwd_data[p*DATA_W +: DATA_W] = stage_result[k*DATA_W +: DATA_W];
                    if (ld_p[k] && (k < LOAD_READY)) begin
                        hazard = 1'b1;
                    end
                end
            end
        end
        hazard = hazard & id_valid;
    end

    assign stall = freeze | (hazard & ~flush);

    // ID -> EX boundary, then EX -> ... -> writeback shift
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= 1'b0;
            end
        end else if (!freeze) begin
            vld_p[0] <= id_valid & ~hazard & ~flush;
            for (int k = 1; k < STAGES; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!freeze) begin
            we_p[0]  <= id_dst_we;
            ld_p[0]  <= id_is_load;
            dst_p[0] <= id_dst_addr;
            for (int k = 1; k < STAGES; k++) begin
                we_p[k]  <= we_p[k-1];
                ld_p[k]  <= ld_p[k-1];
                dst_p[k] <= dst_p[k-1];
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'h0;
        end else if (hazard && !flush && !freeze) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed scenarios plus random traffic against an in-flight queue model.
module tb_pipe_hazard_unit;
    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;
    localparam int READ_PORTS = 2;
    localparam int STAGES     = 2;
    localparam int LOAD_READY = 1;

    logic                             clk = 1'b0;
    logic                             rst;
    logic                             id_valid;
    logic [READ_PORTS*REG_ADDR_W-1:0] id_src_addr;
    logic [READ_PORTS-1:0]            id_src_used;
    logic [REG_ADDR_W-1:0]            id_dst_addr;
    logic                             id_dst_we;
    logic                             id_is_load;
    logic [READ_PORTS*DATA_W-1:0]     rf_rdata;
    logic [STAGES*DATA_W-1:0]         stage_result;
    logic                             flush;
    logic                             freeze;
    logic [READ_PORTS*DATA_W-1:0]     fwd_data;
    logic                             stall;
    logic [31:0]                      stall_count;

    pipe_hazard_unit #(
        .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .READ_PORTS(READ_PORTS),
        .STAGES(STAGES), .LOAD_READY(LOAD_READY)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we),
        .id_is_load(id_is_load), .rf_rdata(rf_rdata), .stage_result(stage_result),
        .flush(flush), .freeze(freeze), .fwd_data(fwd_data), .stall(stall),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                    v;
        bit                    we;
        bit                    ld;
        logic [REG_ADDR_W-1:0] dst;
    } ent_t;

    ent_t        pipe[$];     // index 0 = youngest instruction in flight
    logic [31:0] m_cnt;
    bit          m_hz;
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] port_rf(input int p);
        return rf_rdata[p*DATA_W +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] port_fwd(input int p);
        return fwd_data[p*DATA_W +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] res(input int k);
        return stage_result[k*DATA_W +: DATA_W];
    endfunction

    // Model outputs: first in-flight writer of the source tag (youngest first) supplies the operand.
    task automatic settle_check();
        logic [DATA_W-1:0] exp_d;
        bit                found;
        #1;
        m_hz = 0;
        for (int p = 0; p < READ_PORTS; p++) begin
            exp_d = port_rf(p);
            found = 0;
            for (int i = 0; i < pipe.size(); i++) begin
                if (!found && id_src_used[p] && pipe[i].v && pipe[i].we &&
                    pipe[i].dst == id_src_addr[p*REG_ADDR_W +: REG_ADDR_W]) begin
                    found = 1;
                    exp_d = res(i);
                    if (pipe[i].ld && i < LOAD_READY) m_hz = 1;
                end
            end
            chk($sformatf("fwd_data[%0d]", p), 32'(port_fwd(p)), 32'(exp_d));
        end
        m_hz = m_hz & id_valid;
        chk("stall", 32'(stall), 32'(freeze | (m_hz & ~flush)));
        chk("stall_count", stall_count, m_cnt);
    endtask

    task automatic adv();
        ent_t e;
        @(posedge clk);
        if (rst) begin
            foreach (pipe[i]) pipe[i].v = 0;
            m_cnt = 0;
        end else if (!freeze) begin
`ifdef HAZARD_STALL_CNT_EN
            if (m_hz && !flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
            e.v   = id_valid & ~m_hz & ~flush;
            e.we  = id_dst_we;
            e.ld  = id_is_load;
            e.dst = id_dst_addr;
            pipe.push_front(e);
            void'(pipe.pop_back());
        end
        @(negedge clk);
    endtask

    task automatic issue(input bit v, input logic [3:0] dst, input bit we, input bit ld);
        id_valid = v; id_dst_addr = dst; id_dst_we = we; id_is_load = ld;
        id_src_used = '0;
    endtask

    task automatic cyc();
        settle_check();
        adv();
    endtask

    logic [31:0] exp_cnt_one;

    initial begin
        ent_t e0;
        e0.v = 0; e0.we = 0; e0.ld = 0; e0.dst = '0;
        for (int i = 0; i < STAGES; i++) pipe.push_back(e0);
        m_cnt = 0;
`ifdef HAZARD_STALL_CNT_EN
        exp_cnt_one = 32'd1;
`else
        exp_cnt_one = 32'd0;
`endif
        rst = 1; flush = 0; freeze = 0;
        issue(0, 4'd0, 0, 0);
        id_src_addr = 8'h21; id_src_used = 2'b11;
        rf_rdata = {16'h6666, 16'h5555}; stage_result = {16'h7777, 16'h8888};
        @(negedge clk);
        adv(); adv();
        rst = 0;
        settle_check();
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset stall_count", stall_count, 32'd0);
        chk("reset fwd0", 32'(port_fwd(0)), 32'h5555);
        chk("reset fwd1", 32'(port_fwd(1)), 32'h6666);
        adv();

        // ALU back-to-back
        issue(1, 4'd1, 1, 0); cyc();
        issue(1, 4'd5, 0, 0);
        id_src_addr = 8'h01; id_src_used = 2'b01;
        rf_rdata = '0; stage_result = {16'h0000, 16'h1234};
        settle_check();
        chk("alu fwd0", 32'(port_fwd(0)), 32'h1234);
        chk("alu stall", 32'(stall), 32'd0);
        adv();

        // youngest stage wins
        issue(1, 4'd2, 1, 0); cyc();
        issue(1, 4'd2, 1, 0); cyc();
        issue(0, 4'd0, 0, 0);
        id_src_addr = 8'h20; id_src_used = 2'b10;
        stage_result = {16'hBBBB, 16'hAAAA};
        settle_check();
        chk("prio fwd1", 32'(port_fwd(1)), 32'hAAAA);
        adv();

        // load-use: one bubble, then forward from stage 1
        issue(0, 4'd0, 0, 0); cyc(); cyc();
        issue(1, 4'd3, 1, 1); cyc();
        issue(1, 4'd4, 1, 0);
        id_src_addr = 8'h03; id_src_used = 2'b01;
        stage_result = {16'h0000, 16'h5A5A};
        settle_check();
        chk("lu stall", 32'(stall), 32'd1);
        adv();
        stage_result = {16'h00C3, 16'h0000};
        settle_check();
        chk("lu stall2", 32'(stall), 32'd0);
        chk("lu fwd0", 32'(port_fwd(0)), 32'h00C3);
        chk("lu count", stall_count, exp_cnt_one);
        adv();

        // flush beats hazard
        issue(0, 4'd0, 0, 0); cyc(); cyc();
        issue(1, 4'd3, 1, 1); cyc();
        issue(1, 4'd4, 1, 0);
        id_src_addr = 8'h03; id_src_used = 2'b01; flush = 1;
        settle_check();
        chk("flush stall", 32'(stall), 32'd0);
        adv();
        flush = 0;
        issue(0, 4'd0, 0, 0);
        id_src_addr = 8'h04; id_src_used = 2'b01;
        rf_rdata = {16'h0000, 16'h0101}; stage_result = {16'h0000, 16'hDEAD};
        settle_check();
        chk("flush bubble fwd0", 32'(port_fwd(0)), 32'h0101);
        chk("flush count", stall_count, exp_cnt_one);
        adv();

        // freeze holds tags in flight
        issue(1, 4'd6, 1, 0); cyc();
        issue(1, 4'd7, 1, 0); cyc();
        issue(1, 4'd9, 1, 0); freeze = 1;
        for (int i = 0; i < 3; i++) begin
            settle_check();
            chk("freeze stall", 32'(stall), 32'd1);
            adv();
        end
        freeze = 0;
        issue(0, 4'd0, 0, 0);
        id_src_addr = 8'h76; id_src_used = 2'b11;
        stage_result = {16'h6161, 16'h7171};
        settle_check();
        chk("freeze fwd0", 32'(port_fwd(0)), 32'h6161);
        chk("freeze fwd1", 32'(port_fwd(1)), 32'h7171);
        freeze = 1; rst = 1;
        adv();
        freeze = 0; rst = 0;
        rf_rdata = {16'h4242, 16'h2424};
        settle_check();
        chk("rst-freeze fwd0", 32'(port_fwd(0)), 32'h2424);
        chk("rst-freeze fwd1", 32'(port_fwd(1)), 32'h4242);
        adv();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 99) < 2);
            freeze       = ($urandom_range(0, 99) < 10);
            flush        = ($urandom_range(0, 99) < 10);
            id_valid     = ($urandom_range(0, 99) < 80);
            id_dst_addr  = 4'($urandom_range(0, 3));
            id_dst_we    = ($urandom_range(0, 99) < 75);
            id_is_load   = ($urandom_range(0, 99) < 30);
            id_src_used  = 2'($urandom_range(0, 3));
            id_src_addr  = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            rf_rdata     = 32'($urandom);
            stage_result = 32'($urandom);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
